// File: rtl/alu_pkg.sv
// Shared opcode values and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULU = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unsigned multiply (shift-add) and, with ALU_DIV_EN defined, restoring divide,
// sharing one 2W-bit accumulator and iteration counter. The first step is folded into start.
module alu_iter_unit #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
`ifdef ALU_DIV_EN
  input  logic         div_i,
`endif
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [2*W-1:0] src;
  logic [2*W-1:0] mul_next;
  logic [W-1:0]   opnd_q;
  logic [W-1:0]   opnd;
  logic [W:0]     sum;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
`ifdef ALU_DIV_EN
  logic           div_q;
  logic           div_sel;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic [2*W-1:0] div_next;
`endif

  // Step operands come from the inputs on start, otherwise from the held state.
  always_comb begin
`ifdef ALU_DIV_EN
    div_sel  = start_i ? div_i : div_q;
    opnd     = start_i ? (div_i ? b_i : a_i) : opnd_q;
    src      = start_i ? {{W{1'b0}}, (div_i ? a_i : b_i)} : acc_q;
`else
    opnd     = start_i ? a_i : opnd_q;
    src      = start_i ? {{W{1'b0}}, b_i} : acc_q;
`endif
    sum      = {1'b0, src[2*W-1:W]} + {1'b0, opnd};
    mul_next = src[0] ? {sum, src[W-1:1]} : {1'b0, src[2*W-1:1]};
`ifdef ALU_DIV_EN
    // Remainder stays below the divisor, so diff[W] is exactly the borrow.
    rem_sh   = src[2*W-1:W-1];
    diff     = rem_sh - {1'b0, opnd};
    div_next = diff[W] ? {rem_sh[W-1:0], src[W-2:0], 1'b0}
                       : {diff[W-1:0], src[W-2:0], 1'b1};
    acc_d    = div_sel ? div_next : mul_next;
`else
    acc_d    = mul_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        acc_q  <= acc_d;
        opnd_q <= opnd;
        cnt_q  <= CW'(1);
        busy_q <= 1'b1;
`ifdef ALU_DIV_EN
        div_q  <= div_i;
`endif
      end else if (busy_q) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign hi_o   = acc_q[2*W-1:W];
  assign lo_o   = acc_q[W-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// Datapath ALU: single-cycle logic/arith ops plus iterative MULU/DIVU behind valid/ready.
// Define ALU_DIV_EN to build the divider; otherwise DIVU is an undefined op.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] aluop,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   lo,
  output logic [W-1:0]   hi,
  output logic           zero,
  output logic           err,
  output logic           dz
);

  alu_state_e   state_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [W-1:0] lo_q;
  logic [W-1:0] hi_q;
  logic         zero_q;
  logic         err_q;
  logic         dz_q;

  logic [W-1:0] sc_lo_c;
  logic         sc_err_c;
  logic         is_mul_c;
  logic         is_iter_c;
  logic         start_c;
  logic         iter_done;
  logic [W-1:0] iter_hi;
  logic [W-1:0] iter_lo;
`ifdef ALU_DIV_EN
  logic         is_div_c;
  logic         op_div_q;
  logic         b_zero_q;
`endif

  // Opcode decode and single-cycle results from the live operands.
  always_comb begin
    sc_lo_c  = '0;
    sc_err_c = 1'b0;
    is_mul_c = 1'b0;
`ifdef ALU_DIV_EN
    is_div_c = 1'b0;
`endif
    case (aluop)
      OPW'(ALU_AND):  sc_lo_c = a & b;
      OPW'(ALU_OR):   sc_lo_c = a | b;
      OPW'(ALU_XOR):  sc_lo_c = a ^ b;
      OPW'(ALU_NOR):  sc_lo_c = ~(a | b);
      OPW'(ALU_ADD):  sc_lo_c = a + b;
      OPW'(ALU_SUB):  sc_lo_c = a - b;
      OPW'(ALU_SLT):  sc_lo_c = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OPW'(ALU_SLTU): sc_lo_c = {{(W-1){1'b0}}, (a < b)};
      OPW'(ALU_MULU): is_mul_c = 1'b1;
`ifdef ALU_DIV_EN
      OPW'(ALU_DIVU): is_div_c = 1'b1;
`endif
      default:        sc_err_c = 1'b1;
    endcase
  end

`ifdef ALU_DIV_EN
  assign is_iter_c = is_mul_c | is_div_c;
`else
  assign is_iter_c = is_mul_c;
`endif
  assign start_c = (state_q == S_IDLE) && in_valid && is_iter_c;

  alu_iter_unit #(
    .W(W)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_c),
`ifdef ALU_DIV_EN
    .div_i   (is_div_c),
`endif
    .a_i     (a),
    .b_i     (b),
    .done_o  (iter_done),
    .hi_o    (iter_hi),
    .lo_o    (iter_lo)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      dz_q        <= 1'b0;
`ifdef ALU_DIV_EN
      op_div_q    <= 1'b0;
      b_zero_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_iter_c) begin
              state_q  <= S_BUSY;
`ifdef ALU_DIV_EN
              op_div_q <= is_div_c;
              b_zero_q <= (b == '0);
`endif
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              lo_q        <= sc_lo_c;
              hi_q        <= '0;
              zero_q      <= (sc_lo_c == '0);
              err_q       <= sc_err_c;
              dz_q        <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (iter_done) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            lo_q        <= iter_lo;
            hi_q        <= iter_hi;
            zero_q      <= (iter_lo == '0);
            err_q       <= 1'b0;
`ifdef ALU_DIV_EN
            dz_q        <= op_div_q & b_zero_q;
`else
            dz_q        <= 1'b0;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            dz_q        <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lo        = lo_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, corner sequences, random vs model.
module tb_alu_multicycle;

  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 4;
  localparam int          LAT_ITER = W + 1;
  localparam int          MAX_WAIT = 100;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] aluop;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   lo;
  logic [W-1:0]   hi;
  logic           zero;
  logic           err;
  logic           dz;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] xa;
    logic [31:0] xb;
    logic [31:0] elo;
    logic [31:0] ehi;
    logic        eerr;
    logic        edz;
    int          elat;
  } vec_t;

  vec_t tbl[$];

  alu_multicycle #(.W(W), .OPW(OPW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lo        (lo),
    .hi        (hi),
    .zero      (zero),
    .err       (err),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour computed directly from the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] elo, output logic [31:0] ehi,
                                output logic eerr, output logic edz, output int elat);
    logic [63:0] p;
    elo = '0; ehi = '0; eerr = 1'b0; edz = 1'b0; elat = 1;
    case (op)
      4'd0: elo = x & y;
      4'd1: elo = x | y;
      4'd3: elo = x ^ y;
      4'd4: elo = ~(x | y);
      4'd2: elo = x + y;
      4'd6: elo = x - y;
      4'd7: elo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd5: elo = (x < y) ? 32'd1 : 32'd0;
      4'd8: begin
        p = 64'(x) * 64'(y);
        elo = p[31:0]; ehi = p[63:32]; elat = LAT_ITER;
      end
`ifdef ALU_DIV_EN
      4'd10: begin
        elat = LAT_ITER;
        if (y == 0) begin elo = '1; ehi = x; edz = 1'b1; end
        else begin elo = x / y; ehi = x % y; end
      end
`endif
      default: eerr = 1'b1;
    endcase
  endfunction

  task automatic add(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                     input logic [31:0] elo, input logic [31:0] ehi,
                     input logic eerr, input logic edz, input int elat);
    vec_t v;
    v.op = op; v.xa = xa; v.xb = xb; v.elo = elo; v.ehi = ehi;
    v.eerr = eerr; v.edz = edz; v.elat = elat;
    tbl.push_back(v);
  endtask

  // Present one op, accept it, and wait (bounded) for out_valid; inputs are scrambled after accept.
  task automatic do_op(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                       output int lat, output logic rdy_seen);
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    aluop = op; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; aluop = 4'($urandom);
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < MAX_WAIT) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("retire_out_valid", 64'(out_valid), 64'd0);
    check("retire_in_ready", 64'(in_ready), 64'd1);
    check("retire_flags", {61'd0, zero, err, dz}, 64'd0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int   lat;
    logic rdy_seen;
    do_op(v.op, v.xa, v.xb, lat, rdy_seen);
    check({tag, "_latency"}, 64'(lat), 64'(v.elat));
    check({tag, "_in_ready_low"}, 64'(rdy_seen), 64'd0);
    check({tag, "_lo"}, 64'(lo), 64'(v.elo));
    check({tag, "_hi"}, 64'(hi), 64'(v.ehi));
    check({tag, "_zero"}, 64'(zero), 64'(v.elo == 0));
    check({tag, "_err"}, 64'(err), 64'(v.eerr));
    check({tag, "_dz"}, 64'(dz), 64'(v.edz));
    retire();
  endtask

  initial begin
    logic [31:0] hold_lo;
    logic [31:0] hold_hi;
    int          lat;
    logic        rdy_seen;
    vec_t        v;
    logic [3:0]  ops[13];

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; aluop = '0; a = '0; b = '0;

    add(4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0101, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0101, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 1'b0, 1'b0, 1);
    add(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'd0, 1'b0, 1'b0, 1);
    add(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, LAT_ITER);
    add(4'b1000, 32'd0, 32'd12345, 32'd0, 32'd0, 1'b0, 1'b0, LAT_ITER);
    add(4'b1000, 32'h00010000, 32'h00010000, 32'd0, 32'd1, 1'b0, 1'b0, LAT_ITER);
`ifdef ALU_DIV_EN
    add(4'b1010, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, LAT_ITER);
    add(4'b1010, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b0, 1'b1, LAT_ITER);
    add(4'b1010, 32'd3, 32'd9, 32'd0, 32'd3, 1'b0, 1'b0, LAT_ITER);
`else
    add(4'b1010, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    add(4'b1010, 32'h1234, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1);
`endif
    add(4'b1111, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, 1'b0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_lo_hi", {lo, hi}, 64'd0);
    check("reset_flags", {61'd0, zero, err, dz}, 64'd0);

    foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Result and flags must hold while the consumer stalls.
    do_op(4'b1111, 32'd9, 32'd9, lat, rdy_seen);
    check("stall_latency", 64'(lat), 64'd1);
    hold_lo = lo; hold_hi = hi;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_lo_hi", {lo, hi}, {hold_lo, hold_hi});
      check("stall_flags", {61'd0, zero, err, dz}, 64'b110);
    end
    retire();

    do_op(4'b1000, 32'hDEADBEEF, 32'h01234567, lat, rdy_seen);
    hold_lo = lo;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall_mul_lo", 64'(lo), 64'(hold_lo));
    end
    retire();

    // Reset in the middle of a multiply.
    @(negedge clk);
    aluop = 4'b1000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("mid_mul_busy", 64'({out_valid, in_ready}), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_lo_hi", {lo, hi}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check("midreset_no_stray_result", 64'(out_valid), 64'd0);
    v.op = 4'b1111; v.xa = 32'd7; v.xb = 32'd8; v.elo = '0; v.ehi = '0;
    v.eerr = 1'b1; v.edz = 1'b0; v.elat = 1;
    run_vec("post_reset_undef", v);
    v.op = 4'b1000; v.xa = 32'd3; v.xb = 32'd5; v.elo = 32'd15; v.ehi = '0;
    v.eerr = 1'b0; v.edz = 1'b0; v.elat = LAT_ITER;
    run_vec("post_reset_mul", v);

    // Random operations checked against the reference model.
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd9, 4'd15, 4'd10};
    for (int n = 0; n < 120; n++) begin
      v.op = ops[$urandom_range(0, 12)];
      v.xa = $urandom;
      v.xb = $urandom;
      case ($urandom_range(0, 5))
        0: v.xb = 32'd0;
        1: v.xb = 32'($urandom_range(1, 300));
        2: v.xa = 32'hFFFFFFFF;
        3: v.xa = 32'h80000000;
        default: ;
      endcase
      model(v.op, v.xa, v.xb, v.elo, v.ehi, v.eerr, v.edz, v.elat);
      run_vec($sformatf("rnd%0d_op%0d", n, v.op), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
